// File: rtl/gpu_cmd_fifo.sv
// GP0/GP1 command front-end: GP0 word FIFO with valid/ready drain, single-entry GP1 latch.
// Optional dropped-word counter on ovf_cnt is built only when GPU_CMD_FIFO_OVFCNT_EN is defined.
module gpu_cmd_fifo #(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 16,
  parameter int RDY_MARGIN = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     to_gp0,
  input  logic                     to_gp1,
  input  logic [DATA_W-1:0]        main_bus,
  output logic [DATA_W-1:0]        gp0_data,
  output logic                     gp0_valid,
  input  logic                     gp0_ready,
  output logic [DATA_W-1:0]        gp1_data,
  output logic                     gp1_valid,
  input  logic                     gp1_ack,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     fifo_full,
  output logic                     cmd_rdy,
  output logic                     overflow,
  output logic [7:0]               ovf_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE     = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_RDY_MAX = CNT_W'(DEPTH - RDY_MARGIN);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [7:0]        gp1_op;
  logic              flush;
  logic              push;
  logic              pop;
  logic              drop;

  assign gp1_op = main_bus[DATA_W-1:DATA_W-8];
  assign flush  = to_gp1 && ((gp1_op == 8'h00) || (gp1_op == 8'h01));
  assign pop    = gp0_valid && gp0_ready;
  // GP1 strobes take the bus, so a simultaneous GP0 strobe is lost.
  assign push   = to_gp0 && !to_gp1 && (!fifo_full || pop);
  assign drop   = to_gp0 && !push;

  assign fifo_count = count;
  assign fifo_full  = (count == CNT_FULL);
  assign cmd_rdy    = (count <= CNT_RDY_MAX);
  assign gp0_valid  = (count != '0);
  assign gp0_data   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !flush) begin
      mem[wr_ptr] <= main_bus;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Flush wins over a dropped word landing in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (flush) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gp1_data  <= '0;
      gp1_valid <= 1'b0;
    end else if (to_gp1) begin
      gp1_data  <= main_bus;
      gp1_valid <= 1'b1;
    end else if (gp1_ack) begin
      gp1_valid <= 1'b0;
    end
  end

`ifdef GPU_CMD_FIFO_OVFCNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_cnt <= 8'h00;
    end else if (drop && (ovf_cnt != 8'hFF)) begin
      ovf_cnt <= ovf_cnt + 8'h01;
    end
  end
`else
  assign ovf_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_gpu_cmd_fifo.sv
// Directed bench for gpu_cmd_fifo: a step table for short mixed traffic plus hand-written
// sequences for fill/drain, overflow, full push+pop, flush and reset.
module tb_gpu_cmd_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        to_gp0, to_gp1, gp0_ready, gp1_ack;
  logic [31:0] main_bus;
  logic [31:0] gp0_data, gp1_data;
  logic        gp0_valid, gp1_valid, fifo_full, cmd_rdy, overflow;
  logic [4:0]  fifo_count;
  logic [7:0]  ovf_cnt;

  int checks   = 0;
  int failures = 0;
  int ovf_model = 0;

  typedef struct {
    logic        g0;
    logic        g1;
    logic [31:0] bus;
    logic        rdy;
    logic        ack;
    int          cnt;
    logic        vld;
    logic [31:0] dat;
    logic        ovf;
    logic        g1v;
    logic [31:0] g1d;
    logic        drop;
  } vec_t;

  vec_t vecs [13];

  gpu_cmd_fifo dut (
    .clk(clk), .rst(rst), .to_gp0(to_gp0), .to_gp1(to_gp1), .main_bus(main_bus),
    .gp0_data(gp0_data), .gp0_valid(gp0_valid), .gp0_ready(gp0_ready),
    .gp1_data(gp1_data), .gp1_valid(gp1_valid), .gp1_ack(gp1_ack),
    .fifo_count(fifo_count), .fifo_full(fifo_full), .cmd_rdy(cmd_rdy),
    .overflow(overflow), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_ovf_cnt();
`ifdef GPU_CMD_FIFO_OVFCNT_EN
    return (ovf_model > 255) ? 8'hFF : 8'(ovf_model);
`else
    return 8'h00;
`endif
  endfunction

  task automatic check_state(input string tag, input int cnt, input logic vld,
                             input logic [31:0] dat, input logic ovf,
                             input logic g1v, input logic [31:0] g1d);
    check({tag, " fifo_count"}, 32'(fifo_count), 32'(cnt));
    check({tag, " gp0_valid"},  32'(gp0_valid),  32'(vld));
    if (vld) check({tag, " gp0_data"}, gp0_data, dat);
    check({tag, " fifo_full"},  32'(fifo_full),  32'(cnt == 16));
    check({tag, " cmd_rdy"},    32'(cmd_rdy),    32'(cnt <= 14));
    check({tag, " overflow"},   32'(overflow),   32'(ovf));
    check({tag, " gp1_valid"},  32'(gp1_valid),  32'(g1v));
    check({tag, " gp1_data"},   gp1_data,        g1d);
    check({tag, " ovf_cnt"},    32'(ovf_cnt),    32'(exp_ovf_cnt()));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    to_gp0 = 0; to_gp1 = 0; gp0_ready = 0; gp1_ack = 0; main_bus = '0;
  endtask

  initial begin
    vecs[0]  = '{1, 0, 32'h1111_1111, 0, 0, 1, 1, 32'h1111_1111, 0, 0, 32'h0, 0};
    vecs[1]  = '{1, 0, 32'h2222_2222, 1, 0, 1, 1, 32'h2222_2222, 0, 0, 32'h0, 0};
    vecs[2]  = '{1, 0, 32'h3333_3333, 0, 0, 2, 1, 32'h2222_2222, 0, 0, 32'h0, 0};
    vecs[3]  = '{0, 0, 32'h0,         1, 0, 1, 1, 32'h3333_3333, 0, 0, 32'h0, 0};
    vecs[4]  = '{0, 1, 32'h0200_0005, 0, 0, 1, 1, 32'h3333_3333, 0, 1, 32'h0200_0005, 0};
    vecs[5]  = '{0, 1, 32'h0300_0006, 0, 1, 1, 1, 32'h3333_3333, 0, 1, 32'h0300_0006, 0};
    vecs[6]  = '{0, 0, 32'h0,         0, 1, 1, 1, 32'h3333_3333, 0, 0, 32'h0300_0006, 0};
    vecs[7]  = '{0, 0, 32'h0,         1, 0, 0, 0, 32'h0,         0, 0, 32'h0300_0006, 0};
    vecs[8]  = '{1, 0, 32'h4444_4444, 1, 0, 1, 1, 32'h4444_4444, 0, 0, 32'h0300_0006, 0};
    vecs[9]  = '{1, 1, 32'h0300_0001, 0, 0, 1, 1, 32'h4444_4444, 1, 1, 32'h0300_0001, 1};
    vecs[10] = '{0, 0, 32'h0,         0, 1, 1, 1, 32'h4444_4444, 1, 0, 32'h0300_0001, 0};
    vecs[11] = '{0, 1, 32'h00AB_CDEF, 1, 0, 0, 0, 32'h0,         0, 1, 32'h00AB_CDEF, 0};
    vecs[12] = '{0, 0, 32'h0,         0, 1, 0, 0, 32'h0,         0, 0, 32'h00AB_CDEF, 0};

    // Reset held while GP0 strobes arrive: nothing may be accepted.
    idle();
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      to_gp0 = 1; main_bus = 32'hA000_0000 + 32'(i);
      tick();
      check_state("reset", 0, 0, 32'h0, 0, 0, 32'h0);
      check("reset gp0_data", gp0_data, 32'h0);
    end
    idle();
    rst = 1;
    tick();
    check_state("post_reset", 0, 0, 32'h0, 0, 0, 32'h0);

    for (int v = 0; v < 13; v++) begin
      to_gp0 = vecs[v].g0; to_gp1 = vecs[v].g1; main_bus = vecs[v].bus;
      gp0_ready = vecs[v].rdy; gp1_ack = vecs[v].ack;
      if (vecs[v].drop) ovf_model++;
      tick();
      check_state($sformatf("vec%0d", v), vecs[v].cnt, vecs[v].vld, vecs[v].dat,
                  vecs[v].ovf, vecs[v].g1v, vecs[v].g1d);
    end
    idle();

    // Fill to DEPTH without draining.
    for (int i = 0; i < 16; i++) begin
      to_gp0 = 1; main_bus = 32'h1000_0000 + 32'(i);
      tick();
      check_state($sformatf("fill%0d", i), i + 1, 1, 32'h1000_0000, 0, 0, 32'h00AB_CDEF);
    end

    // Push while full with no pop is dropped.
    main_bus = 32'hDEAD_BEEF;
    ovf_model++;
    tick();
    check_state("ovf_full", 16, 1, 32'h1000_0000, 1, 0, 32'h00AB_CDEF);

    // Push with concurrent pop at full is accepted.
    main_bus = 32'h2000_0000; gp0_ready = 1;
    tick();
    check_state("full_push_pop", 16, 1, 32'h1000_0001, 1, 0, 32'h00AB_CDEF);

    to_gp0 = 0;
    for (int i = 0; i < 16; i++) begin
      check(($sformatf("drain%0d data", i)), gp0_data,
            (i < 15) ? 32'h1000_0001 + 32'(i) : 32'h2000_0000);
      tick();
      check($sformatf("drain%0d count", i), 32'(fifo_count), 32'(15 - i));
    end
    check("drained valid", 32'(gp0_valid), 32'h0);
    idle();

    // Five words queued, then flush with a concurrent pop request.
    for (int i = 0; i < 5; i++) begin
      to_gp0 = 1; main_bus = 32'h5000_0000 + 32'(i);
      tick();
    end
    check_state("pre_flush", 5, 1, 32'h5000_0000, 1, 0, 32'h00AB_CDEF);
    to_gp0 = 0; to_gp1 = 1; gp0_ready = 1; main_bus = 32'h0100_0000;
    tick();
    idle();
    check_state("flush", 0, 0, 32'h0, 0, 1, 32'h0100_0000);
    tick();
    tick();
    check_state("flush_hold", 0, 0, 32'h0, 0, 1, 32'h0100_0000);
    gp1_ack = 1;
    tick();
    gp1_ack = 0;
    check_state("flush_ack", 0, 0, 32'h0, 0, 0, 32'h0100_0000);

    // Words pushed after a flush start from a clean FIFO.
    to_gp0 = 1; main_bus = 32'h6000_0006;
    tick();
    to_gp0 = 0;
    check_state("after_flush", 1, 1, 32'h6000_0006, 0, 0, 32'h0100_0000);

    // Asynchronous reset mid-transfer with a GP1 word pending.
    to_gp1 = 1; main_bus = 32'h0200_0002;
    tick();
    idle();
    check_state("pre_rst", 1, 1, 32'h6000_0006, 0, 1, 32'h0200_0002);
    #3;
    rst = 0;
    #1;
    ovf_model = 0;
    check_state("async_rst", 0, 0, 32'h0, 0, 0, 32'h0);
    tick();
    rst = 1;
    tick();
    check_state("final", 0, 0, 32'h0, 0, 0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
